axi_lut_multiplier: RTL and testbench

Parametrised AXI4-Lite read master that serves multiply requests from a pre-initialised product table in memory. It is the successor to the 3-bit times-table reader: operand width, data width, base address and request queue depth are parameters. Request and result sides use full valid/ready handshakes, and read errors are reported. It sits between the operand-producing logic and any AXI4-Lite memory slave holding the table, with entry `a*b` at word index `{a,b}`.

---
 rtl/axi_mult_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/axi_lut_multiplier.sv | 137 +++++++++++++
 tb/tb_axi_lut_multiplier.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mult_pkg.sv
// Shared types and helpers for the AXI4-Lite product-table reader.
package axi_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Table entries are 32-bit words; callers truncate to their address width.
  function automatic logic [63:0] lut_addr(input logic [63:0] base, input logic [63:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; power-of-two depth so pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axi_lut_multiplier.sv
// Queues operand pairs and fetches each product a*b from a table in AXI4-Lite memory.
module axi_lut_multiplier
  import axi_mult_pkg::*;
#(
  parameter int unsigned        OP_W       = 3,
  parameter int unsigned        RES_W      = 2*OP_W,
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DATA_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam int unsigned IDX_W = 2*OP_W;

  state_e              state_q;
  logic                init_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic                arvalid_q, rready_q, res_valid_q, res_err_q;
  logic [RES_W-1:0]    res_data_q;

  logic [IDX_W-1:0]    q_dout;
  logic                q_full, q_empty, q_push, q_pop;
  logic [ADDR_W-1:0]   araddr_d;
  logic                rd_err;

  // init_q keeps req_ready low until the first edge after reset release.
  assign req_ready = init_q && !q_full;
  assign q_push    = req_valid && req_ready;
  assign q_pop     = !q_empty && ((state_q == ST_IDLE) || (state_q == ST_OUT && res_ready));
  assign araddr_d  = ADDR_W'(lut_addr(64'(BASE_ADDR), 64'(q_dout)));
  assign rd_err    = (m_axi_rresp == RESP_SLVERR) || (m_axi_rresp == RESP_DECERR);

  sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .din_i   ({req_a, req_b}),
    .pop_i   (q_pop),
    .dout_o  (q_dout),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      init_q      <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!q_empty) begin
            araddr_q  <= araddr_d;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_axi_rvalid) begin
            rready_q    <= 1'b0;
            res_valid_q <= 1'b1;
            res_err_q   <= rd_err;
            res_data_q  <= rd_err ? '0 : m_axi_rdata[RES_W-1:0];
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            // Chain straight into the next read to keep the 3-cycle cadence.
            if (!q_empty) begin
              araddr_q  <= araddr_d;
              arvalid_q <= 1'b1;
              state_q   <= ST_ADDR;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  generate
    if (RES_W < DATA_W) begin : g_rdata_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^m_axi_rdata[DATA_W-1:RES_W];
    end
  endgenerate

  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign busy          = !q_empty || (state_q != ST_IDLE);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lut_multiplier.sv
// Bench: product-table AXI slave model, request scoreboard, and directed scenarios.
module tb_axi_lut_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_a, req_b;
  logic        res_valid, res_ready;
  logic [5:0]  res_data;
  logic        res_err, busy;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  logic        r4_valid, r4_ready, s4_valid, s4_ready, s4_err, busy4;
  logic [3:0]  r4_a, r4_b;
  logic [7:0]  s4_data;
  logic [31:0] araddr4, rdata4;
  logic [2:0]  arprot4;
  logic        arvalid4, arready4, rvalid4, rready4;
  logic [1:0]  rresp4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_lut_multiplier dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  axi_lut_multiplier #(.OP_W(4), .BASE_ADDR(32'h1000)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_a(r4_a), .req_b(r4_b),
    .res_valid(s4_valid), .res_ready(s4_ready), .res_data(s4_data), .res_err(s4_err),
    .busy(busy4),
    .m_axi_araddr(araddr4), .m_axi_arprot(arprot4), .m_axi_arvalid(arvalid4), .m_axi_arready(arready4),
    .m_axi_rdata(rdata4), .m_axi_rresp(rresp4), .m_axi_rvalid(rvalid4), .m_axi_rready(rready4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- memory slave holding the 3-bit product table ----------------
  int          cfg_ar_stall = 0;
  int          cfg_r_delay  = 0;
  logic        cfg_err_en   = 1'b0;
  logic [5:0]  cfg_err_idx  = 6'd0;
  int          acnt, rcnt;
  logic        pend;
  logic [31:0] paddr;

  function automatic logic slv_err(input logic [31:0] addr);
    return cfg_err_en && (addr[7:2] == cfg_err_idx);
  endfunction

  function automatic logic [31:0] slv_data(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (slv_err(addr)) return 32'hDEAD_BEEF;
    return ((idx >> 3) & 32'd7) * (idx & 32'd7);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      pend <= 1'b0; acnt <= 0; rcnt <= 0; paddr <= '0;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        acnt    <= 0;
        arready <= (cfg_ar_stall == 0);
        if (cfg_r_delay == 0) begin
          rvalid <= 1'b1; rdata <= slv_data(araddr); rresp <= slv_err(araddr) ? 2'b10 : 2'b00;
        end else begin
          pend <= 1'b1; paddr <= araddr; rcnt <= 1;
        end
      end else if (arvalid) begin
        if (acnt + 1 >= cfg_ar_stall) arready <= 1'b1;
        acnt <= acnt + 1;
      end else begin
        arready <= (cfg_ar_stall == 0);
      end
      if (pend) begin
        if (rcnt >= cfg_r_delay) begin
          rvalid <= 1'b1; rdata <= slv_data(paddr); rresp <= slv_err(paddr) ? 2'b10 : 2'b00;
          pend <= 1'b0;
        end else begin
          rcnt <= rcnt + 1;
        end
      end
    end
  end

  // Zero-wait slave for the 4-bit instance (table based at 0x1000).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid4 <= 1'b0; rdata4 <= '0;
    end else if (arvalid4 && arready4) begin
      rvalid4 <= 1'b1;
      rdata4  <= (((araddr4 - 32'h1000) >> 6) & 32'hF) * (((araddr4 - 32'h1000) >> 2) & 32'hF);
    end else if (rvalid4 && rready4) begin
      rvalid4 <= 1'b0;
    end
  end
  assign rresp4 = 2'b00;

  // ---------------- scoreboard: every accepted request yields one result, in order ----------------
  logic [6:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic        in_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete(); addr_q.delete(); in_data = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        logic e;
        e = cfg_err_en && ({req_a, req_b} == cfg_err_idx);
        exp_q.push_back({e, e ? 6'd0 : 6'(req_a * req_b)});
        addr_q.push_back(32'(req_a) * 32 + 32'(req_b) * 4);
      end
      if (arvalid && arready) in_data = 1'b1;
      if (rvalid && rready)   in_data = 1'b0;
    end
  end

  logic        ar_hold = 1'b0, res_hold = 1'b0;
  logic [31:0] held_addr;
  logic [6:0]  held_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      ar_hold = 1'b0; res_hold = 1'b0;
    end else begin
      if (ar_hold) begin
        chk("ar_hold_valid", arvalid, 1'b1);
        chk("ar_hold_addr", araddr, held_addr);
      end
      if (arvalid && arready) begin
        if (addr_q.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
        else chk("araddr", araddr, addr_q.pop_front());
      end
      ar_hold = arvalid && !arready; held_addr = araddr;
      if (in_data) begin
        chk("rready_in_data", rready, 1'b1);
        chk("single_outstanding", arvalid, 1'b0);
      end
      if (res_hold) begin
        chk("res_hold_valid", res_valid, 1'b1);
        chk("res_hold_data", {res_err, res_data}, held_res);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("res_unexpected", 1'b1, 1'b0);
        else chk("result", {res_err, res_data}, exp_q.pop_front());
      end
      res_hold = res_valid && !res_ready; held_res = {res_err, res_data};
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b);
    int t = 0;
    req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && t < 50) begin tick(1); t++; end
    if (t >= 50) chk("send_timeout", 1'b1, 1'b0);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic get_res(output logic [5:0] d, output logic e);
    int t = 0;
    while (!res_valid && t < 100) begin tick(1); t++; end
    if (t >= 100) chk("res_timeout", 1'b1, 1'b0);
    d = res_data; e = res_err;
    tick(1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || res_valid) && t < 200) begin tick(1); t++; end
    if (t >= 200) chk("idle_timeout", 1'b1, 1'b0);
  endtask

  logic [5:0] d;
  logic       e;
  int         exp2 [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
    r4_valid = 1'b0; r4_a = '0; r4_b = '0; s4_ready = 1'b1; arready4 = 1'b1;
    tick(3);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_outputs", {res_valid, res_err, busy, arvalid, rready}, 5'b0);
    chk("rst_res_data", res_data, 6'd0);
    chk("rst_araddr", araddr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("req_ready_pre_edge", req_ready, 1'b0);
    tick(1);
    chk("req_ready_post_edge", req_ready, 1'b1);
    tick(1);

    // 3x5 with a zero-wait slave: latency and address
    send(3'd3, 3'd5);
    chk("lat_n0_arvalid", arvalid, 1'b0);
    tick(1);
    chk("lat_n1_arvalid", arvalid, 1'b1);
    chk("addr_3x5", araddr, 32'h74);
    chk("arprot", arprot, 3'b000);
    tick(1);
    chk("lat_n2_res_valid", res_valid, 1'b0);
    tick(1);
    chk("lat_n3_res_valid", res_valid, 1'b1);
    chk("res_3x5", {res_err, res_data}, {1'b0, 6'd15});
    tick(1);
    wait_idle();

    // fill the queue under backpressure, then drain in order
    res_ready = 1'b0;
    send(3'd7, 3'd7); send(3'd0, 3'd6); send(3'd2, 3'd3); send(3'd7, 3'd1);
    chk("ready_after_4", req_ready, 1'b1);
    send(3'd5, 3'd5);
    chk("ready_when_full", req_ready, 1'b0);
    chk("busy_when_full", busy, 1'b1);
    tick(4);
    chk("stalled_first", {res_valid, res_data}, {1'b1, 6'd49});
    res_ready = 1'b1;
    exp2 = '{49, 0, 6, 7, 25};
    for (int i = 0; i < 5; i++) begin
      get_res(d, e);
      chk("drain_order", {e, d}, {1'b0, 6'(exp2[i])});
    end
    wait_idle();

    // slow slave: stalled AR and delayed R
    cfg_ar_stall = 3; cfg_r_delay = 2;
    tick(2);
    send(3'd6, 3'd7);
    get_res(d, e);
    chk("slow_6x7", {e, d}, {1'b0, 6'd42});
    wait_idle();
    cfg_ar_stall = 0; cfg_r_delay = 0;
    tick(2);

    // error response, then a clean read
    cfg_err_en = 1'b1; cfg_err_idx = 6'o44;
    send(3'd4, 3'd4); send(3'd2, 3'd2);
    get_res(d, e);
    chk("err_4x4", {e, d}, {1'b1, 6'd0});
    get_res(d, e);
    chk("after_err_2x2", {e, d}, {1'b0, 6'd4});
    wait_idle();
    cfg_err_en = 1'b0;

    // reset while a read is in flight with two requests queued
    cfg_r_delay = 6;
    send(3'd1, 3'd1); send(3'd2, 3'd1); send(3'd3, 3'd1);
    tick(1);
    chk("pre_rst_in_data", rready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {req_ready, res_valid, res_err, busy, arvalid, rready}, 6'b0);
    chk("mid_rst_data", {araddr, 2'b00, res_data}, 40'd0);
    cfg_r_delay = 0;
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", req_ready, 1'b1);
    send(3'd6, 3'd5);
    get_res(d, e);
    chk("post_rst_6x5", {e, d}, {1'b0, 6'd30});
    wait_idle();

    // wider instance at a non-zero base
    r4_a = 4'd15; r4_b = 4'd15; r4_valid = 1'b1;
    begin
      int t = 0;
      while (!r4_ready && t < 20) begin tick(1); t++; end
      tick(1); r4_valid = 1'b0;
      t = 0;
      while (!arvalid4 && t < 20) begin tick(1); t++; end
      chk("w4_addr", araddr4, 32'h13FC);
      t = 0;
      while (!s4_valid && t < 20) begin tick(1); t++; end
      chk("w4_res", {s4_valid, s4_err, s4_data}, {1'b1, 1'b0, 8'd225});
    end
    tick(2);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
